// File: rtl/figo_route_fsm.sv
// Route-walking FSM for a linear corridor of rooms: one plan bit per accepted move,
// with a move budget, a trap room and sticky terminal status flags.
module figo_route_fsm #(
    parameter int unsigned LOC_W     = 3,
    parameter int unsigned N_ROOMS   = 8,
    parameter int unsigned TRAP_ROOM = 2,
    parameter int unsigned MAX_MOVES = 12,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_plan_valid,
    input  logic             i_travel_plan,
    output logic             o_plan_ready,
    output logic [LOC_W-1:0] o_current_location,
    output logic [CNT_W-1:0] o_move_count,
    output logic             o_busy,
    output logic             o_arrived,
    output logic             o_trapped,
    output logic             o_lost,
    output logic             o_done_pulse
);

    typedef enum logic [2:0] {StIdle, StWalk, StArrived, StTrapped, StLost} state_e;

    localparam logic [LOC_W-1:0] GoalLoc = LOC_W'(N_ROOMS - 1);
    localparam logic [LOC_W-1:0] TrapLoc = LOC_W'(TRAP_ROOM);
    localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_MOVES);

    state_e           r_state;
    logic [LOC_W-1:0] r_loc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_plan_ready;
    logic             r_busy;
    logic             r_arrived;
    logic             r_trapped;
    logic             r_lost;
    logic             r_done;

    logic [LOC_W-1:0] w_next_loc;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_hit_goal;
    logic             w_hit_trap;
    logic             w_hit_budget;
    logic             w_accept;

    // Outcome of the move on the plan inputs, assuming it gets accepted this edge.
    always_comb begin
        w_next_loc = r_loc;
        w_hit_goal = 1'b0;
        w_hit_trap = 1'b0;
        w_next_cnt = r_cnt + CNT_W'(1);
        if (i_travel_plan) begin
            w_next_loc = r_loc + LOC_W'(1);
            w_hit_goal = (w_next_loc == GoalLoc);
        end else if (r_loc == TrapLoc) begin
            w_hit_trap = 1'b1;
        end else if (r_loc != '0) begin
            w_next_loc = r_loc - LOC_W'(1);
        end
        w_hit_budget = (w_next_cnt == MaxCnt);
        w_accept     = i_plan_valid & r_plan_ready & (r_state == StWalk);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_loc        <= '0;
            r_cnt        <= '0;
            r_plan_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_arrived    <= 1'b0;
            r_trapped    <= 1'b0;
            r_lost       <= 1'b0;
            r_done       <= 1'b0;
        end else if (i_start) begin
            // A move presented alongside start is dropped.
            r_state      <= StWalk;
            r_loc        <= '0;
            r_cnt        <= '0;
            r_plan_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_arrived    <= 1'b0;
            r_trapped    <= 1'b0;
            r_lost       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_loc <= w_next_loc;
                r_cnt <= w_next_cnt;
                if (w_hit_goal || w_hit_trap || w_hit_budget) begin
                    r_plan_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                end
                if (w_hit_goal) begin
                    r_state   <= StArrived;
                    r_arrived <= 1'b1;
                end else if (w_hit_trap) begin
                    r_state   <= StTrapped;
                    r_trapped <= 1'b1;
                end else if (w_hit_budget) begin
                    r_state <= StLost;
                    r_lost  <= 1'b1;
                end
            end
        end
    end

    assign o_plan_ready       = r_plan_ready;
    assign o_current_location = r_loc;
    assign o_move_count       = r_cnt;
    assign o_busy             = r_busy;
    assign o_arrived          = r_arrived;
    assign o_trapped          = r_trapped;
    assign o_lost             = r_lost;
    assign o_done_pulse       = r_done;

endmodule
